// File: rtl/expr_scheduler_pkg.sv
// expr_scheduler_pkg
// Shared types for the resource-shared six-output expression scheduler:
//   NUM_STEPS - number of datapath steps (C1..C11) in one job
//   state_t   - scheduler states IDLE, C1..C11, DONE
//   alu_op_t  - adder/subtractor operation select
package expr_scheduler_pkg;

  localparam int NUM_STEPS = 11;

  // IDLE + NUM_STEPS compute states + DONE
  typedef enum logic [$clog2(NUM_STEPS + 2)-1:0] {
    IDLE,
    C1, C2, C3, C4, C5, C6, C7, C8, C9, C10, C11,
    DONE
  } state_t;

  typedef enum logic {
    ADD,
    SUB
  } alu_op_t;

endpackage

// File: rtl/expr_alu.sv
// expr_alu
// Shared combinational arithmetic unit: one adder/subtractor and one
// truncated multiplier. All results wrap modulo 2^WIDTH.
// Ports:
//   op        - ADD or SUB for the adder/subtractor
//   a, b      - adder/subtractor operands (result = a+b or a-b)
//   ma, mb    - multiplier operands
//   sum       - adder/subtractor result
//   prod      - low WIDTH bits of ma*mb
module expr_alu
  import expr_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ma,
  input  logic [WIDTH-1:0] mb,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] prod
);

  assign sum  = (op == SUB) ? (a - b) : (a + b);
  // Same-width operands and result: the product is truncated to WIDTH bits
  assign prod = ma * mb;

endmodule

// File: rtl/expr_scheduler.sv
// expr_scheduler
// Sequences the six-output expression block over a single shared
// multiplier and adder/subtractor using a fixed 11-step schedule that
// computes X*Y once and reuses it.
// Ports:
//   clk, rst_n            - clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   - operand handshake; operands sampled only in IDLE
//   x,y,z,p,q,r,s,t       - WIDTH-bit operands
//   out_valid / out_ready - result handshake; results held while stalled
//   out1..out6            - WIDTH-bit results
//   busy                  - high while in C1..C11
//   job_count             - completed-job counter, present only when
//                           EXPR_SCHEDULER_JOB_CNT_EN is defined
module expr_scheduler
  import expr_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic             busy
`ifdef EXPR_SCHEDULER_JOB_CNT_EN
  ,
  output logic [31:0]      job_count
`endif
);

  state_t state;

  logic [WIDTH-1:0] rx, ry, rz, rp, rq, rr, rs, rt;
  logic [WIDTH-1:0] t_xy, t_m, t_qr, t_xyp, t_pz, t_mq, t_px, t_st, t_mr;

  alu_op_t          alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_ma, alu_mb, alu_sum, alu_prod;

  expr_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .ma   (alu_ma),
    .mb   (alu_mb),
    .sum  (alu_sum),
    .prod (alu_prod)
  );

  // Operand steering for the shared unit; idle steps drive zeros
  always_comb begin
    alu_op = ADD;
    alu_a  = '0;
    alu_b  = '0;
    alu_ma = '0;
    alu_mb = '0;
    case (state)
      C1:  begin alu_a = rx;   alu_b = ry;   alu_ma = rx;    alu_mb = ry;   end
      C2:  begin alu_op = SUB; alu_a = rq;   alu_b = rr;                     end
      C3:  begin alu_a = t_xy; alu_b = rp;                                   end
      C4:  begin alu_a = rp;   alu_b = rz;   alu_ma = t_xyp; alu_mb = t_qr; end
      C5:  begin alu_a = t_m;  alu_b = t_pz; alu_ma = t_pz;  alu_mb = t_qr; end
      C6:  begin alu_a = t_m;  alu_b = rq;                                   end
      C7:  begin alu_a = rp;   alu_b = rx;                                   end
      C8:  begin alu_a = rs;   alu_b = rt;   alu_ma = t_mq;  alu_mb = t_px; end
      C9:  begin alu_a = t_xy; alu_b = t_st;                                 end
      C10: begin alu_op = SUB; alu_a = t_m;  alu_b = rr;                     end
      C11: begin alu_op = SUB; alu_a = t_mr; alu_b = rx;                     end
      default: ;
    endcase
  end

  // Schedule FSM: each step registers its ALU results and advances;
  // handshake flags are registered alongside the state transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      {rx, ry, rz, rp, rq, rr, rs, rt} <= '0;
      {t_xy, t_m, t_qr, t_xyp, t_pz, t_mq, t_px, t_st, t_mr} <= '0;
      {out1, out2, out3, out4, out5, out6} <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {rx, ry, rz, rp, rq, rr, rs, rt} <= {x, y, z, p, q, r, s, t};
          state    <= C1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        C1:  begin t_xy  <= alu_sum; t_m  <= alu_prod; state <= C2;  end
        C2:  begin t_qr  <= alu_sum;                   state <= C3;  end
        C3:  begin t_xyp <= alu_sum;                   state <= C4;  end
        C4:  begin t_pz  <= alu_sum; out6 <= alu_prod; state <= C5;  end
        C5:  begin out1  <= alu_sum; out2 <= alu_prod; state <= C6;  end
        C6:  begin t_mq  <= alu_sum;                   state <= C7;  end
        C7:  begin t_px  <= alu_sum;                   state <= C8;  end
        C8:  begin t_st  <= alu_sum; out4 <= alu_prod; state <= C9;  end
        C9:  begin out3  <= alu_sum;                   state <= C10; end
        C10: begin t_mr  <= alu_sum;                   state <= C11; end
        C11: begin
          out5      <= alu_sum;
          state     <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        // A new job is never accepted here; in_valid waits for IDLE
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXPR_SCHEDULER_JOB_CNT_EN
  // Counts completed output handshakes; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n)
      job_count <= '0;
    else if (state == DONE && out_ready)
      job_count <= job_count + 32'd1;
  end
`endif

endmodule
